sap_controller: RTL

Controller-sequencer for the SAP_U computer: sits directly upstream of the register A/B, ALU, RAM/MAR and bus-manager datapath and produces every control signal they consume. A step counter walks fetch and execute micro-steps T0–T4. A microcode lookup decodes the current opcode from the instruction register and the ALU flags into the control word for each step. The block also handles halt and programming-mode hold.

---
 rtl/sap_pkg.sv | 49 ++++
 rtl/sap_microcode_rom.sv | 109 ++++++++++
 rtl/sap_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP_U controller: opcodes, step encodings and control-word layout.
// SAP_COND_JUMP_EN (optional) enables the flags register and conditional jumps JC/JZ.
package sap_pkg;

  localparam int STEPS    = 5;
  localparam int OPCODE_W = 4;
  localparam int STEP_W   = 3;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;

  // Control-word bits are stored active-high (1 = asserted); polarity is applied at the ports.
  localparam int CW_W   = 17;
  localparam int CW_PCO = 0;   // PC to bus
  localparam int CW_J   = 1;   // PC jump
  localparam int CW_CE  = 2;   // PC increment
  localparam int CW_II  = 3;   // IR load
  localparam int CW_IO  = 4;   // IR low nibble to bus
  localparam int CW_MI  = 5;   // MAR load
  localparam int CW_RO  = 6;   // RAM to bus
  localparam int CW_WE  = 7;   // RAM write enable
  localparam int CW_RC  = 8;   // RAM data from bus
  localparam int CW_AI  = 9;   // A load
  localparam int CW_AO  = 10;  // A to bus
  localparam int CW_BI  = 11;  // B load
  localparam int CW_EO  = 12;  // ALU to bus
  localparam int CW_OI  = 13;  // OUT load
  localparam int CW_SU  = 14;  // ALU subtract
  localparam int CW_HLT = 15;  // set halted
  localparam int CW_FI  = 16;  // capture flags

  localparam logic [CW_W-1:0] CW_IDLE = 17'h0_0000;

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (opcode, step, carry, zero) -> {control word, last-step}.
// JC/JZ decode only when SAP_COND_JUMP_EN is defined; otherwise 0x7/0x8 fall to NOP.
module sap_microcode_rom
  import sap_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [STEP_W-1:0]   step,
  input  logic                carry,
  input  logic                zero,
  output logic [CW_W-1:0]     cw,
  output logic                last
);

`ifndef SAP_COND_JUMP_EN
  logic unused_flags_s;
  assign unused_flags_s = carry ^ zero;
`endif

  always_comb begin
    cw   = CW_IDLE;
    last = 1'b0;
    case (step)
      T0: begin
        cw[CW_PCO] = 1'b1;
        cw[CW_MI]  = 1'b1;
      end
      T1: begin
        cw[CW_RO] = 1'b1;
        cw[CW_II] = 1'b1;
        cw[CW_CE] = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IO] = 1'b1;
            cw[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IO] = 1'b1;
            cw[CW_AI] = 1'b1;
            last      = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IO] = 1'b1;
            cw[CW_J]  = 1'b1;
            last      = 1'b1;
          end
`ifdef SAP_COND_JUMP_EN
          OP_JC: begin
            cw[CW_IO] = 1'b1;
            cw[CW_J]  = carry;
            last      = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IO] = 1'b1;
            cw[CW_J]  = zero;
            last      = 1'b1;
          end
`endif
          OP_OUT: begin
            cw[CW_AO] = 1'b1;
            cw[CW_OI] = 1'b1;
            last      = 1'b1;
          end
          OP_HLT: begin
            cw[CW_HLT] = 1'b1;
            last       = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RO] = 1'b1;
            cw[CW_AI] = 1'b1;
            last      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RO] = 1'b1;
            cw[CW_BI] = 1'b1;
            cw[CW_SU] = (opcode == OP_SUB);
          end
          OP_STA: begin
            cw[CW_AO] = 1'b1;
            cw[CW_WE] = 1'b1;
            cw[CW_RC] = 1'b1;
            last      = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      T4: begin
        last = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB: begin
            cw[CW_EO] = 1'b1;
            cw[CW_AI] = 1'b1;
            cw[CW_FI] = 1'b1;
            cw[CW_SU] = (opcode == OP_SUB);
          end
          default: cw = CW_IDLE;
        endcase
      end
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/sap_controller.sv
// SAP_U controller-sequencer: step counter, halt, flags and reset/halt/prog_mode gating.
// SAP_COND_JUMP_EN (optional) adds the carry/zero flags register used by JC/JZ.
module sap_controller
  import sap_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_in,
  input  logic                zero_in,
  input  logic                prog_mode,
  output logic                pc_bus_enable_n,
  output logic                pc_jump_n,
  output logic                pc_inc,
  output logic                ir_load_n,
  output logic                ir_bus_enable_n,
  output logic                ram_load_mar_reg_n,
  output logic                ram_bus_enable_n,
  output logic                ram_write_enable_n,
  output logic                ram_control_signal,
  output logic                reg_a_load_n,
  output logic                reg_a_bus_enable_n,
  output logic                reg_b_load_n,
  output logic                alu_enable_n,
  output logic                out_load_n,
  output logic                alu_subtract,
  output logic                halted,
  output logic [STEP_W-1:0]   step
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  logic [CW_W-1:0]   rom_cw_s, cw_s;
  logic              rom_last_s;
  logic              carry_s, zero_s;

`ifdef SAP_COND_JUMP_EN
  logic carry_q, carry_d, zero_q, zero_d;

  always_comb begin
    if (cw_s[CW_FI]) begin
      carry_d = carry_in;
      zero_d  = zero_in;
    end else begin
      carry_d = carry_q;
      zero_d  = zero_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry_s = carry_q;
  assign zero_s  = zero_q;
`else
  logic unused_flags_s;
  assign unused_flags_s = carry_in ^ zero_in ^ cw_s[CW_FI];
  assign carry_s = 1'b0;
  assign zero_s  = 1'b0;
`endif

  sap_microcode_rom u_rom (
    .opcode (opcode),
    .step   (step_q),
    .carry  (carry_s),
    .zero   (zero_s),
    .cw     (rom_cw_s),
    .last   (rom_last_s)
  );

  // Reset, halt and programming mode all silence the datapath controls.
  always_comb begin
    if (!reset || halted_q || prog_mode) begin
      cw_s = CW_IDLE;
    end else begin
      cw_s = rom_cw_s;
    end
  end

  always_comb begin
    if (halted_q) begin
      step_d   = T0;
      halted_d = 1'b1;
    end else if (prog_mode) begin
      step_d   = T0;
      halted_d = 1'b0;
    end else begin
      step_d   = rom_last_s ? T0 : step_q + 3'd1;
      halted_d = cw_s[CW_HLT];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign pc_bus_enable_n    = ~cw_s[CW_PCO];
  assign pc_jump_n          = ~cw_s[CW_J];
  assign pc_inc             =  cw_s[CW_CE];
  assign ir_load_n          = ~cw_s[CW_II];
  assign ir_bus_enable_n    = ~cw_s[CW_IO];
  assign ram_load_mar_reg_n = ~cw_s[CW_MI];
  assign ram_bus_enable_n   = ~cw_s[CW_RO];
  assign ram_write_enable_n = ~cw_s[CW_WE];
  assign ram_control_signal =  cw_s[CW_RC];
  assign reg_a_load_n       = ~cw_s[CW_AI];
  assign reg_a_bus_enable_n = ~cw_s[CW_AO];
  assign reg_b_load_n       = ~cw_s[CW_BI];
  assign alu_enable_n       = ~cw_s[CW_EO];
  assign out_load_n         = ~cw_s[CW_OI];
  assign alu_subtract       =  cw_s[CW_SU];
  assign halted             = halted_q;
  assign step               = step_q;

endmodule
